rms_sequencer: RTL

//  Multicycle control FSM that sequences the register management system (64x16 regfile, CR write path,
//  w2 source mux, comparator, call-frame save/restore). Accepts one 4-bit opcode per instruction from

---
 rtl/rms_pkg.sv | 48 ++++
 rtl/rms_mem_timer.sv | 40 ++++
 rtl/rms_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/rms_pkg.sv
// Package: rms_pkg
// Shared definitions for the rms sequencer slice: FSM state encoding,
// instruction opcodes, w2 source-select codes and the CR register address.
package rms_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_LI   = 4'd4,
        OP_LW   = 4'd5,
        OP_SW   = 4'd6,
        OP_MOV  = 4'd7,
        OP_BEQ  = 4'd8,
        OP_BNE  = 4'd9,
        OP_SLT  = 4'd10,
        OP_CALL = 4'd11,
        OP_RET  = 4'd12,
        OP_NOP  = 4'd13,
        OP_ILL  = 4'd14,
        OP_HALT = 4'd15
    } opcode_t;

    // w2 write-source select
    localparam logic [1:0] REGSRC_IMM = 2'd0;
    localparam logic [1:0] REGSRC_ALU = 2'd1;
    localparam logic [1:0] REGSRC_MEM = 2'd2;
    localparam logic [1:0] REGSRC_A   = 2'd3;

    // Condition register, target of the w1 path when writeCR is set
    localparam logic [5:0] CR_ADDR = 6'd57;

    // Opcodes 0..3 all take the ALU result through the w2 path
    function automatic logic is_alu_op(input opcode_t o);
        return (o == OP_ADD) || (o == OP_SUB) || (o == OP_AND) || (o == OP_OR);
    endfunction

endpackage

// File: rtl/rms_mem_timer.sv
// Module: rms_mem_timer
// Memory-handshake watchdog. Loaded with MEM_TIMEOUT when a request is
// issued, counts down once per cycle while non-zero, cleared by ack.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   start       load the counter (request about to be issued)
//   ack         memory answered; stop counting
//   expired     high during the last allowed request cycle
module rms_mem_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic ack,
    output logic expired
);

    localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (start) begin
            count <= CW'(MEM_TIMEOUT);
        end else if (ack) begin
            count <= '0;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    // First request cycle sees MEM_TIMEOUT, so count==1 marks cycle number MEM_TIMEOUT
    always_comb begin
        expired = (count == CW'(1));
    end

endmodule

// File: rtl/rms_sequencer.sv
// Module: rms_sequencer
// Multicycle control FSM for the register management system. Accepts one
// opcode at a time over instr_valid/instr_ready, walks it through
// DECODE/EXEC/(MEM)/(WB) and drives the regfile strobes, mux selects,
// comparator mode, call-frame strobes and the data-memory handshake.
// Optional feature macro: RMS_SEQ_DEPTH_CHECK_EN (call-depth checking).
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   instr_valid/instr_ready    fetch handshake; op sampled on accept
//   cmp_result                 comparator result, used in EXEC of BEQ/BNE
//   mem_ack                    data memory completion
//   RegR1/RegR2/RegW1/RegW2    regfile read/write strobes
//   writeCR, Regsrc            a1=CR select, w2 source select
//   cmpeq/cmpne                comparator mode
//   restore/fc_save            call-frame restore/save strobes
//   mem_rd/mem_wr              memory request, held until ack or timeout
//   pc_write/pc_branch         PC update and branch-target select
//   halted/bus_err/illegal     sticky status
module rms_sequencer
    import rms_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned MAX_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [3:0] op,
    input  logic       cmp_result,
    input  logic       mem_ack,
    output logic       RegR1,
    output logic       RegR2,
    output logic       RegW1,
    output logic       RegW2,
    output logic       writeCR,
    output logic [1:0] Regsrc,
    output logic       cmpeq,
    output logic       cmpne,
    output logic       restore,
    output logic       fc_save,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       pc_write,
    output logic       pc_branch,
    output logic       halted,
    output logic       bus_err,
    output logic       illegal
);

    state_t  state, state_next;
    opcode_t op_q;
    logic    mem_op;
    logic    timer_start;
    logic    timer_expired;
    logic    frame_fault;

    always_comb begin
        mem_op      = (op_q == OP_LW) || (op_q == OP_SW);
        timer_start = (state == S_EXEC) && mem_op;
    end

    rms_mem_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (timer_start),
        .ack     (mem_ack && (state == S_MEM)),
        .expired (timer_expired)
    );

`ifdef RMS_SEQ_DEPTH_CHECK_EN
    localparam int unsigned DW = $clog2(MAX_DEPTH + 1);

    logic [DW-1:0] depth;

    always_comb begin
        frame_fault = (state == S_EXEC) &&
                      (((op_q == OP_CALL) && (depth == DW'(MAX_DEPTH))) ||
                       ((op_q == OP_RET)  && (depth == '0)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth <= '0;
        end else if ((state == S_EXEC) && !frame_fault) begin
            if (op_q == OP_CALL) begin
                depth <= depth + DW'(1);
            end else if (op_q == OP_RET) begin
                depth <= depth - DW'(1);
            end
        end
    end
`else
    // No depth tracking; MAX_DEPTH is kept only so both builds share one interface
    always_comb begin
        frame_fault = 1'b0 & (MAX_DEPTH == 0);
    end
`endif

    // State, op and sticky status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            op_q    <= OP_ADD;
            bus_err <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state <= state_next;
            if ((state == S_IDLE) && instr_valid) begin
                op_q <= opcode_t'(op);
            end
            if (((state == S_DECODE) && (op_q == OP_ILL)) || frame_fault) begin
                illegal <= 1'b1;
            end
            // An ack in the expiring cycle takes priority over the timeout
            if ((state == S_MEM) && timer_expired && !mem_ack) begin
                bus_err <= 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (instr_valid) state_next = S_DECODE;
            S_DECODE: begin
                if (op_q == OP_ILL)       state_next = S_IDLE;
                else if (op_q == OP_HALT) state_next = S_HALT;
                else                      state_next = S_EXEC;
            end
            S_EXEC: begin
                if (mem_op) begin
                    state_next = S_MEM;
                end else if (is_alu_op(op_q) || (op_q == OP_LI) ||
                             (op_q == OP_MOV) || (op_q == OP_SLT)) begin
                    state_next = S_WB;
                end else begin
                    state_next = S_IDLE;
                end
            end
            // SW also passes through WB so its pc_write stays a pure state decode
            S_MEM: begin
                if (mem_ack)            state_next = S_WB;
                else if (timer_expired) state_next = S_IDLE;
            end
            S_WB:     state_next = S_IDLE;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_IDLE;
        endcase
    end

    // Moore output decode (pc_branch follows cmp_result during branch EXEC)
    always_comb begin
        instr_ready = (state == S_IDLE);
        halted      = (state == S_HALT);
        RegR1       = 1'b0;
        RegR2       = 1'b0;
        RegW1       = 1'b0;
        RegW2       = 1'b0;
        writeCR     = 1'b0;
        Regsrc      = REGSRC_IMM;
        cmpeq       = 1'b0;
        cmpne       = 1'b0;
        restore     = 1'b0;
        fc_save     = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        pc_write    = 1'b0;
        pc_branch   = 1'b0;
        case (state)
            S_DECODE: begin
                RegR1 = 1'b1;
                RegR2 = 1'b1;
            end
            S_EXEC: begin
                case (op_q)
                    OP_BEQ: begin
                        cmpeq     = 1'b1;
                        pc_write  = 1'b1;
                        pc_branch = cmp_result;
                    end
                    OP_BNE: begin
                        cmpne     = 1'b1;
                        pc_write  = 1'b1;
                        pc_branch = cmp_result;
                    end
                    OP_CALL: begin
                        fc_save   = !frame_fault;
                        pc_write  = !frame_fault;
                        pc_branch = !frame_fault;
                    end
                    OP_RET: begin
                        restore  = !frame_fault;
                        pc_write = !frame_fault;
                    end
                    OP_NOP:  pc_write = 1'b1;
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_rd = (op_q == OP_LW);
                mem_wr = (op_q == OP_SW);
            end
            S_WB: begin
                pc_write = 1'b1;
                case (op_q)
                    OP_LI:  begin RegW2 = 1'b1; Regsrc = REGSRC_IMM; end
                    OP_MOV: begin RegW2 = 1'b1; Regsrc = REGSRC_A;   end
                    OP_LW:  begin RegW2 = 1'b1; Regsrc = REGSRC_MEM; end
                    OP_SLT: begin RegW1 = 1'b1; writeCR = 1'b1;      end
                    default: begin
                        if (is_alu_op(op_q)) begin
                            RegW2  = 1'b1;
                            Regsrc = REGSRC_ALU;
                        end
                    end
                endcase
            end
            default: ;
        endcase
    end

endmodule
